// File: rtl/cd_prio_irq.sv
// -----------------------------------------------------------------------------
// cd_prio_irq
// Registered priority encoder with pending latches, per-input masking and a
// valid/ready output handshake. Requests are latched into a pending register
// (rising-edge or level capture), and the best unmasked pending index is
// presented on o/v. It stays there until the consumer accepts it.
//
// Parameters
//   N    : number of request inputs (N >= 2)
//   EDGE : 1 = capture rising edges of req, 0 = capture while req is high
//   RR   : 0 = fixed priority (highest index wins), 1 = round-robin
//   W    : index width, $clog2(N)
//
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset
//   req   : [N-1:0] request lines
//   mask  : [N-1:0] 1 = input not eligible (its pending bit is kept)
//   ready : consumer accepts o when v & ready at an edge
//   o     : [W-1:0] registered index of the presented request
//   v     : registered valid for o
//   ovf   : sticky overflow, a request hit an already-pending input
// -----------------------------------------------------------------------------
module cd_prio_irq #(
  parameter  int N    = 8,
  parameter  int EDGE = 1,
  parameter  int RR   = 0,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ready,
  output logic [W-1:0] o,
  output logic         v,
  output logic         ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   p_q, p_d;
  logic [N-1:0]   req_dly_q, req_dly_d;
  logic [W-1:0]   o_q, o_d;
  logic [W-1:0]   last_q, last_d;
  logic           ovf_q, ovf_d;

  logic [N-1:0]   set_vec;
  logic [N-1:0]   clr_vec;
  logic [N-1:0]   elig;
  logic           accept;
  logic [W-1:0]   base;
  logic           sel_found;
  logic [W-1:0]   sel_idx;

  assign v   = (state_q == PRESENT);
  assign o   = o_q;
  assign ovf = ovf_q;

  // Capture, accept-clear and eligibility.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the block leaves it unassigned and infers a latch.
    set_vec = (EDGE != 0) ? (req & ~req_dly_q) : req;
    accept  = v & ready;
    clr_vec = '0;
    if (accept) clr_vec[o_q] = 1'b1;
    // A bit that is re-set in the same cycle it is accepted survives the clear,
    // so it stays eligible for the very next selection.
    elig    = p_q & ~(clr_vec & ~set_vec) & ~mask;
    // On an accept the rotation pivots on the index being accepted, which is
    // the value last takes at this edge.
    base    = accept ? o_q : last_q;
  end

  // Selection: walk candidates from lowest to highest priority and let later
  // hits overwrite earlier ones, so the last hit is the winner. The modulo
  // keeps round-robin indices below N when N is not a power of two.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (RR != 0) ? ((int'(base) - k + N) % N) : (N - k);
      if (elig[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx[W-1:0];
      end
    end
  end

  // Next-state for the pending register, overflow and the handshake FSM.
  always_comb begin
    p_d       = (p_q & ~clr_vec) | set_vec;
    ovf_d     = ovf_q | (|(set_vec & p_q & ~clr_vec));
    req_dly_d = req;
    state_d   = state_q;
    o_d       = o_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          o_d     = sel_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Without an accept o and v hold, whatever mask or req do.
        if (accept) begin
          last_d = o_q;
          if (sel_found) o_d = sel_idx;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      req_dly_q <= '0;
      o_q       <= '0;
      last_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      req_dly_q <= req_dly_d;
      o_q       <= o_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: doc/cd_prio_irq.md
# cd_prio_irq

Parametrised, registered priority encoder with pending latches, per-input masking and a valid/ready output handshake. N request lines are captured into a pending register (edge or level mode). The highest-priority unmasked pending index is presented on `o` with `v` and held until accepted. The block sits between raw request sources (interrupt lines, FIFO flags) and a single consumer, and replaces flat combinational encoders wherever requests must not be lost and the consumer may stall.

## Interface
- `N`, default 8: number of request inputs; legal range is N ≥ 2.
- `EDGE`, default 1: 1 = capture rising edges of `req`; 0 = capture while `req` is high (level).
- `RR`, default 0: 0 = fixed priority, where the highest index wins; 1 = round-robin, rotating after each accept.
- `W` (localparam) = $clog2(N): width of the index output.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N: request lines, sampled every edge.
- `mask`  in  N: 1 = input i is not eligible for selection. Its pending bit is kept.
- `ready`  in  1: consumer accepts the presented index when `v` and `ready` are both 1 at an edge.
- `o`  out  W: registered index of the presented request.
- `v`  out  1: registered valid; `o` is meaningful only while `v` = 1.
- `ovf`  out  1: sticky overflow; a request arrived on an input whose pending bit was already set.

## Operation
**Reset** (while `rst` = 1 at an edge):
- P (pending) = 0, `req_d` = 0, `o` = 0, `v` = 0, `ovf` = 0, `last` = 0.
- Reset overrides every other event in the same cycle, including an in-flight handshake; pending requests are discarded.

**Set condition** for input i:
- EDGE = 1: `req[i] & ~req_d[i]`. Because `req_d` resets to 0, a line held high through reset counts as an edge at the first edge after reset.
- EDGE = 0: `req[i]`.

**Pending register P:**
- P[i] sets on the set condition.
- P[i] clears on accept of index i.
- If set and accept-clear of the same bit coincide, set wins and P[i] stays 1.
- In level mode, a line still high is therefore re-presented after it is accepted.

**Overflow:**
- `ovf` sets when the set condition for i occurs while P[i] = 1 and the same cycle is not an accept of i.
- `ovf` clears only on reset.

**Eligibility:** E = P & ~mask, evaluated after the accept-clear of the current cycle and before the new sets.

**Selection:**
- RR = 0: highest set index of E.
- RR = 1: search from (last−1) mod N downward with wrap-around; the first set bit of E wins.
- After reset, `last` = 0, so the first round-robin search starts at N−1 and matches fixed priority.

**Two-state FSM, IDLE (`v` = 0) and PRESENT (`v` = 1):**
- IDLE: if E ≠ 0, load `o` = selected index, `v` = 1, and go to PRESENT. Otherwise stay.
- PRESENT, `ready` = 0: `o` and `v` hold stable. Mask or request changes never retract or alter a presented index.
- PRESENT, `ready` = 1 (accept): clear P[o] and set `last` = `o`. If E (excluding `o`, unless `o` was re-set) ≠ 0, load the next selected index and stay in PRESENT with `v` = 1. Otherwise go to IDLE with `v` = 0.
- An index that becomes masked after it has been presented is still delivered.

**Arithmetic:** all index arithmetic is modulo N on W bits. N need not be a power of two, and indices ≥ N are never produced.

## Timing
- Latency from request to valid is 2 edges.
  - `req[i]` is first sampled high at edge k, so P[i] = 1 after edge k.
  - `v` = 1 with `o` = i after edge k+1, assuming an idle block, i unmasked and i the top priority.
- Accept occurs at the edge where `v` & `ready` = 1. The next index, if any, appears after that same edge, giving back-to-back throughput of one index per cycle.
- `ready` while `v` = 0 is ignored.
- Outputs are fully registered, with no combinational path from `req`, `mask` or `ready` to `o`, `v` or `ovf`.
- Unmasking a pending input in IDLE makes `v` = 1 after the next edge.

## Test plan
- Reset behaviour: N=8, EDGE=1, RR=0, pulse `req` = 8'h00 → 8'h90 for 1 cycle, `ready` = 0 → `o` = 7 and `v` = 1 two edges after the sample, held. Pulse `ready` → `o` = 4, `v` = 1 next edge. Pulse again → `v` = 0.
- Masking: P = 8'h81 with `mask` = 8'h80 → `o` = 0. Set `mask` = 0 while `o` = 0 is presented → `o` stays 0 until accept, then `o` = 7.
- Round-robin: N=8, RR=1, `req` held steady = 8'h85 (level mode, EDGE=0), `ready` = 1 continuously → `o` sequence 7, 2, 0, 7, 2, 0…, with `v` continuously 1.
- Overflow: EDGE=1, two rising edges on `req[3]` with no accept in between → `ovf` = 1 and stays 1. Accept `o` = 3 once → `v` drops (single pending). `ovf` remains 1 until `rst`.
- Non-power-of-two and reset: N=5, RR=1, `req` = 5'h11 held through reset.
  - First edge after reset: P = 5'h11, then `o` = 4, then after accept `o` = 0.
  - Assert `rst` while `v` = 1 → `v` = 0, `o` = 0, `ovf` = 0 after that edge.
